regfile_writeback_arbiter: RTL and testbench
============================================

# regfile_writeback_arbiter

Initiator side of the register-file write port. Collects write-back requests from the ALU and load/store paths through valid/ready handshakes, arbitrates them round-robin, buffers them in a small in-order queue, and drains one entry per cycle into the register file's single write port (`write_enable`/`write_reg`/`write_data`). It also reports whether a given register still has a write queued, for the decode stall logic.

## Interface
- `DEPTH`, 4: queue entries; power of two, ≥2.
- `ADDR_W`, 5: register index width.
- `DATA_W`, 32: data width.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `alu_valid`  in  1  ALU write-back request.
- `alu_reg`  in  ADDR_W  ALU destination register.
- `alu_data`  in  DATA_W  ALU result.
- `alu_ready`  out  1  ALU request accepted this cycle.
- `mem_valid`  in  1  load write-back request.
- `mem_reg`  in  ADDR_W  load destination register.
- `mem_data`  in  DATA_W  load result.
- `mem_ready`  out  1  load request accepted this cycle.
- `wb_hold`  in  1  block draining; the register-file port is borrowed elsewhere.
- `rf_write_enable`  out  1  to register-file `write_enable`.
- `rf_write_reg`  out  ADDR_W  to register-file `write_reg`.
- `rf_write_data`  out  DATA_W  to register-file `write_data`.
- `lookup_reg`  in  ADDR_W  register index queried by decode.
- `pending_hit`  out  1  `lookup_reg` has a queued or draining write.
- `count`  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- **Transfer:** a transfer occurs on a port when `valid && ready`. At most one port is granted per cycle.
- **Arbitration:**
  - Only one port valid: that port is granted.
  - Both ports valid: grant goes to the port not granted last.
  - `last_grant` updates only on an actual transfer.
  - After reset, ALU wins the first tie.
- **Ready:** `ready` = granted && (`count < DEPTH` || `!wb_hold`). The ready of the non-granted port is 0.
- **Queue:**
  - A transfer with reg ≠ 0 enqueues {reg, data} at the tail.
  - A transfer with reg == 0 is accepted and discarded: not enqueued, `count` unchanged.
- **Drain:**
  - When `count > 0` and `!wb_hold`, the head is presented on `rf_write_*` with `rf_write_enable`=1 and is popped at the clock edge.
  - Otherwise `rf_write_enable`=0, `rf_write_reg`=0 and `rf_write_data`=0.
- **Ordering:** strict grant order. Repeated writes to one register land in acceptance order, so the last accepted value wins.
- **Simultaneous push and pop:** `count` is unchanged. When full, a push is allowed only with a pop in the same cycle.
- **`pending_hit`:** combinational. Asserted if `lookup_reg` ≠ 0 and it matches any occupied entry, including the head currently draining. Forced 0 for `lookup_reg` == 0.
- **Reset:**
  - `rst_n`=0 at an edge empties the queue (`count`=0, pointers 0) and sets `last_grant` to MEM.
  - Queued writes are lost. There is no partial drain.
  - While `rst_n`=0: `alu_ready`=`mem_ready`=0 and `rf_write_enable`=0.

## Timing
- **Latency:** without bypass, a request accepted at edge N drives `rf_write_enable` during cycle N+1 at the earliest. Each held cycle adds one.
- **Throughput:** one accept and one drain per cycle.
- **Output source:** `rf_write_*` come from registered queue storage and the pointers. There is no combinational input-to-output path except under the bypass macro.
- **Combinational inputs:** `alu_ready`/`mem_ready` depend combinationally on both valids, `count` and `wb_hold`.
- **Reset values:** `alu_ready` 0, `mem_ready` 0, `rf_write_enable` 0, `rf_write_reg` 0, `rf_write_data` 0, `pending_hit` 0 (queue empty), `count` 0.

## Configuration
- **`REGFILE_WB_BYPASS_EN` defined:**
  - When `count`==0, `!wb_hold` and a transfer with reg ≠ 0 occurs, the write is driven on `rf_write_*` in the same cycle and is not enqueued. Latency is 0.
  - `pending_hit` also covers that bypassed write.
- **Undefined:** behaviour is exactly as above, with 1-cycle minimum latency.

## Structure
- **`regfile_pkg`:** `ADDR_W`, `DATA_W`, `wb_entry_t` {reg, data} and the grant enum {GRANT_ALU, GRANT_MEM}.
- **Sub-module `wb_fifo`:** synchronous FIFO of `wb_entry_t`. It provides push/pop/count/head plus per-entry valid/reg outputs for the `pending_hit` compare.
- **Top level:** arbitration, ready generation, r0 discard and bypass.

## Test plan
- **Single write:** after reset, `alu_valid`=1, `alu_reg`=3, `alu_data`=0xDEADBEEF for one cycle → `alu_ready`=1; next cycle `rf_write_enable`=1, `rf_write_reg`=3, `rf_write_data`=0xDEADBEEF; `count` back to 0 the cycle after.
- **Tie arbitration:** both valid every cycle, ALU reg 1 = 0xA, MEM reg 2 = 0xB → grants alternate ALU, MEM, ALU…; the drained sequence is reg1, reg2, reg1…
- **Hold and full:** `wb_hold`=1 with 5 ALU requests to regs 4..8 → first 4 accepted, `count`=4, `alu_ready`=0 on the 5th. Release hold → pop and push in the same cycle; drains 4,5,6,7,8 in order.
- **r0 and pending_hit:** a write to reg 0 is accepted with `count` unchanged and never drained. With reg 9 queued under hold, `lookup_reg`=9 → `pending_hit`=1, and `lookup_reg`=0 → `pending_hit`=0.
- **Reset mid-operation:** 3 entries queued under hold, `rst_n`=0 for one edge → `count`=0, no `rf_write_enable`, and the next tie grants ALU.
- **Bypass (`REGFILE_WB_BYPASS_EN`):** empty queue, MEM write reg 5 = 0x1234 → `rf_write_enable`=1, reg 5 = 0x1234 in the same cycle; `count` stays 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types for the register-file write-back path.
//   ADDR_W, DATA_W : register index and data widths
//   wb_entry_t     : one queued write {dst, data}
//   grant_e        : which requester owns the write-back slot
package regfile_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 32;

  // "reg" is a keyword, so the destination field is called dst.
  typedef struct packed {
    logic [ADDR_W-1:0] dst;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    GRANT_ALU = 1'b0,
    GRANT_MEM = 1'b1
  } grant_e;

endpackage

// File: rtl/wb_fifo.sv
// In-order write-back queue.
//   clk, rst_n   : clock, synchronous active-low reset (empties the queue)
//   push         : enqueue push_entry at the tail (caller guarantees space)
//   pop          : drop the head (caller guarantees non-empty)
//   head         : oldest entry
//   count        : occupied entries
//   entry_valid  : per-slot occupancy, for register-match lookups
//   entry_dst    : per-slot destination register
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               push,
  input  wb_entry_t                          push_entry,
  input  logic                               pop,
  output wb_entry_t                          head,
  output logic [$clog2(DEPTH):0]             count,
  output logic [DEPTH-1:0]                   entry_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]       entry_dst
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  wb_entry_t           mem_q [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q;
  logic [PtrW-1:0]     off;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // DEPTH is a power of two, so pointers wrap naturally.
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage is not reset; occupancy comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

  // A slot is occupied when its distance from the head is below count.
  always_comb begin
    off = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      off            = PtrW'(i) - rd_ptr_q;
      entry_valid[i] = {1'b0, off} < count_q;
      entry_dst[i]   = mem_q[i].dst;
    end
  end

endmodule

// File: rtl/regfile_writeback_arbiter.sv
// Register-file write-back arbiter.
// Round-robin arbitration of ALU and load write-back requests into an in-order
// queue that drains one write per cycle into the register file's write port.
//   clk, rst_n               : clock, synchronous active-low reset
//   alu_valid/reg/data/ready : ALU write-back handshake
//   mem_valid/reg/data/ready : load write-back handshake
//   wb_hold                  : stall draining (port borrowed elsewhere)
//   rf_write_enable/reg/data : register-file write port
//   lookup_reg, pending_hit  : "write still queued" query for decode
//   count                    : occupied queue entries
// Build option: define REGFILE_WB_BYPASS_EN to drive a write straight to the
// register file in the accepting cycle when the queue is empty and not held.
module regfile_writeback_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    alu_valid,
  input  logic [ADDR_W-1:0]       alu_reg,
  input  logic [DATA_W-1:0]       alu_data,
  output logic                    alu_ready,
  input  logic                    mem_valid,
  input  logic [ADDR_W-1:0]       mem_reg,
  input  logic [DATA_W-1:0]       mem_data,
  output logic                    mem_ready,
  input  logic                    wb_hold,
  output logic                    rf_write_enable,
  output logic [ADDR_W-1:0]       rf_write_reg,
  output logic [DATA_W-1:0]       rf_write_data,
  input  logic [ADDR_W-1:0]       lookup_reg,
  output logic                    pending_hit,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  grant_e                        last_grant_q, last_grant_d, grant;
  logic                          can_accept, xfer, drain, bypass, push, hit;
  wb_entry_t                     xfer_entry, head;
  logic [CntW-1:0]               fifo_count;
  logic [DEPTH-1:0]              entry_valid;
  logic [DEPTH-1:0][ADDR_W-1:0]  entry_dst;

  always_ff @(posedge clk) begin
    if (!rst_n) last_grant_q <= GRANT_MEM;  // so ALU wins the first tie
    else        last_grant_q <= last_grant_d;
  end

  always_comb begin
    grant = GRANT_ALU;
    if (alu_valid && mem_valid) begin
      grant = (last_grant_q == GRANT_ALU) ? GRANT_MEM : GRANT_ALU;
    end else if (mem_valid) begin
      grant = GRANT_MEM;
    end

    // When full, a push is only safe if the head drains this same cycle.
    can_accept = rst_n && ((fifo_count < FullCnt) || !wb_hold);
    alu_ready  = can_accept && alu_valid && (grant == GRANT_ALU);
    mem_ready  = can_accept && mem_valid && (grant == GRANT_MEM);
    xfer       = alu_ready || mem_ready;

    xfer_entry = alu_ready ? wb_entry_t'{dst: alu_reg, data: alu_data}
                           : wb_entry_t'{dst: mem_reg, data: mem_data};
    last_grant_d = xfer ? grant : last_grant_q;

    drain  = rst_n && (fifo_count != '0) && !wb_hold;
    bypass = 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
    bypass = xfer && (xfer_entry.dst != '0) && (fifo_count == '0) && !wb_hold;
`endif
    // r0 writes are accepted but never stored.
    push = xfer && (xfer_entry.dst != '0) && !bypass;

    rf_write_enable = 1'b0;
    rf_write_reg    = '0;
    rf_write_data   = '0;
    if (drain) begin
      rf_write_enable = 1'b1;
      rf_write_reg    = head.dst;
      rf_write_data   = head.data;
    end else if (bypass) begin
      rf_write_enable = 1'b1;
      rf_write_reg    = xfer_entry.dst;
      rf_write_data   = xfer_entry.data;
    end

    hit = bypass && (xfer_entry.dst == lookup_reg);
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (entry_valid[i] && (entry_dst[i] == lookup_reg)) hit = 1'b1;
    end
    pending_hit = hit && (lookup_reg != '0);
  end

  assign count = fifo_count;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_entry  (xfer_entry),
    .pop         (drain),
    .head        (head),
    .count       (fifo_count),
    .entry_valid (entry_valid),
    .entry_dst   (entry_dst)
  );

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Randomised bench for regfile_writeback_arbiter. A driver issues requests and
// records accepted writes in a scoreboard queue; a monitor compares every
// register-file write, count and pending_hit against that queue.
module tb_regfile_writeback_arbiter;

  localparam int DEPTH = 4;
  localparam int NCYC  = 900;
  localparam int NTAIL = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, mem_valid, wb_hold;
  logic [4:0]  alu_reg, mem_reg, lookup_reg;
  logic [31:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, rf_write_enable, pending_hit;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic [2:0]  count;

  always #5 clk = ~clk;

  regfile_writeback_arbiter #(
    .DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alu_valid       (alu_valid),
    .alu_reg         (alu_reg),
    .alu_data        (alu_data),
    .alu_ready       (alu_ready),
    .mem_valid       (mem_valid),
    .mem_reg         (mem_reg),
    .mem_data        (mem_data),
    .mem_ready       (mem_ready),
    .wb_hold         (wb_hold),
    .rf_write_enable (rf_write_enable),
    .rf_write_reg    (rf_write_reg),
    .rf_write_data   (rf_write_data),
    .lookup_reg      (lookup_reg),
    .pending_hit     (pending_hit),
    .count           (count)
  );

  typedef struct {
    logic [4:0]  dst;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];   // accepted writes not yet drained, oldest first
  bit  byp_valid;  // a same-cycle write is expected (bypass build only)
  wr_t byp_e;
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Driver and reference model of acceptance.
  initial begin
    bit  last_mem;   // last actual transfer was from MEM
    bit  pend_push;
    wr_t pend_e, e;
    bit  exp_alu, exp_mem, do_byp;
    int  hold_pct, valid_pct;

    rst_n = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0; wb_hold = 1'b0;
    alu_reg = '0; mem_reg = '0; alu_data = '0; mem_data = '0; lookup_reg = '0;
    byp_valid = 1'b0; pend_push = 1'b0; last_mem = 1'b1;

    for (int cyc = 0; cyc < NCYC + NTAIL; cyc++) begin
      @(posedge clk); #1;
      if (pend_push) exp_q.push_back(pend_e);
      pend_push = 1'b0;
      if (!rst_n) begin
        exp_q.delete();
        last_mem = 1'b1;
      end
      byp_valid = 1'b0;

      if      (cyc < 300) begin hold_pct = 10; valid_pct = 50; end
      else if (cyc < 600) begin hold_pct = 75; valid_pct = 80; end
      else                begin hold_pct = 30; valid_pct = 90; end

      rst_n = !(cyc < 2 || cyc == 450 || cyc == 700);
      if (cyc >= NCYC) begin
        alu_valid = 1'b0; mem_valid = 1'b0; wb_hold = 1'b0;
      end else begin
        alu_valid = ($urandom_range(99) < valid_pct);
        mem_valid = ($urandom_range(99) < valid_pct);
        wb_hold   = ($urandom_range(99) < hold_pct);
      end
      alu_reg    = 5'($urandom_range(7));
      mem_reg    = 5'($urandom_range(7));
      alu_data   = $urandom;
      mem_data   = $urandom;
      lookup_reg = 5'($urandom_range(7));
      #1;

      exp_alu = 1'b0;
      exp_mem = 1'b0;
      if (rst_n && (exp_q.size() < DEPTH || !wb_hold)) begin
        if (alu_valid && mem_valid) begin
          if (last_mem) exp_alu = 1'b1;
          else          exp_mem = 1'b1;
        end else if (alu_valid) begin
          exp_alu = 1'b1;
        end else if (mem_valid) begin
          exp_mem = 1'b1;
        end
      end
      check("alu_ready", alu_ready, exp_alu);
      check("mem_ready", mem_ready, exp_mem);

      if (exp_alu || exp_mem) begin
        e.dst    = exp_alu ? alu_reg : mem_reg;
        e.data   = exp_alu ? alu_data : mem_data;
        last_mem = exp_mem;
        if (e.dst != 5'd0) begin
          do_byp = 1'b0;
`ifdef REGFILE_WB_BYPASS_EN
          do_byp = (exp_q.size() == 0) && !wb_hold;
`endif
          if (do_byp) begin
            byp_valid = 1'b1;
            byp_e     = e;
          end else begin
            pend_push = 1'b1;
            pend_e    = e;
          end
        end
      end
    end

    @(posedge clk); #1;
    if (pend_push) exp_q.push_back(pend_e);
    check("drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Monitor: compare the write port, count and pending_hit each cycle.
  initial begin
    bit  exp_en, exp_hit;
    wr_t w;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rf_we_in_reset", rf_write_enable, 0);
      end else begin
        check("count", count, exp_q.size());
        exp_en = 1'b0;
        w.dst  = '0;
        w.data = '0;
        if (exp_q.size() > 0 && !wb_hold) begin
          exp_en = 1'b1;
          w      = exp_q[0];
        end else if (byp_valid) begin
          exp_en = 1'b1;
          w      = byp_e;
        end
        check("rf_write_enable", rf_write_enable, exp_en);
        check("rf_write_reg", rf_write_reg, w.dst);
        check("rf_write_data", rf_write_data, w.data);

        exp_hit = byp_valid && (byp_e.dst == lookup_reg);
        foreach (exp_q[i]) if (exp_q[i].dst == lookup_reg) exp_hit = 1'b1;
        if (lookup_reg == 5'd0) exp_hit = 1'b0;
        check("pending_hit", pending_hit, exp_hit);

        if (exp_q.size() > 0 && !wb_hold) void'(exp_q.pop_front());
      end
    end
  end

endmodule
